// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with a valid/ready load handshake, supporting gapless back-to-back words.
// Bits go out MSB-first by default. Define PISO_TX_LSB_FIRST_EN to send them LSB-first instead.
module piso_tx #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   shreg, shreg_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [WIDTH-1:0]   shreg_shifted;
  logic               head_bit;

`ifdef PISO_TX_LSB_FIRST_EN
  assign shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
  assign head_bit      = shreg[0];
`else
  assign shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
  assign head_bit      = shreg[WIDTH-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = cnt;
    sout       = 1'b0;
    sout_valid = 1'b0;
    last       = 1'b0;
    ready      = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (load) begin
          state_next = SHIFT;
          shreg_next = d;
          cnt_next   = '0;
        end
      end
      SHIFT: begin
        sout       = head_bit;
        sout_valid = 1'b1;
        busy       = 1'b1;
        last       = (cnt == CNT_W'(WIDTH - 1));
        ready      = last;
        if (!last) begin
          shreg_next = shreg_shifted;
          cnt_next   = cnt + CNT_W'(1);
        end else if (load) begin
          // Reload on the final bit so the next word follows with no idle cycle.
          shreg_next = d;
          cnt_next   = '0;
        end else begin
          state_next = IDLE;
          shreg_next = '0;
          cnt_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
